// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, ROM addressing, instruction register with valid/ready to decode.
// Optional FETCH_JMP_FOLD_EN: jmp instructions are resolved here instead of being issued.
module fetch_unit #(
    parameter int unsigned          ADDR_W   = 4,
    parameter int unsigned          INST_W   = 16,
    parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [INST_W-1:0] rom_data,
    output logic [INST_W-1:0] ir,
    output logic [ADDR_W-1:0] ir_pc,
    output logic              ir_valid,
    input  logic              ir_ready,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_target,
    output logic [ADDR_W-1:0] pc
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [INST_W-1:0]   ir_q;
    logic [ADDR_W-1:0]   ir_pc_q;
    logic                load_ir;
    logic                slot_free;
    logic                transfer;
    logic                fold_jmp;

    assign slot_free = (state_q == EMPTY) | ir_ready;
    assign transfer  = (state_q == FULL) & ir_ready;

`ifdef FETCH_JMP_FOLD_EN
    logic [ADDR_W-1:0] jmp_target;
    assign jmp_target = rom_data[ADDR_W+7:8];
    assign fold_jmp   = (rom_data[INST_W-1 -: 4] == 4'b1000);
`else
    assign fold_jmp   = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir_q    <= '0;
            ir_pc_q <= '0;
        end else if (load_ir) begin
            ir_q    <= rom_data;
            ir_pc_q <= pc_q;
        end
    end

    // A folded jmp always leaves the slot empty: a free slot was either empty or just transferred.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        load_ir = 1'b0;
        if (redirect_valid) begin
            pc_d    = redirect_target;
            state_d = EMPTY;
        end else if (fetch_en && slot_free) begin
            if (fold_jmp) begin
`ifdef FETCH_JMP_FOLD_EN
                pc_d    = jmp_target;
`endif
                state_d = EMPTY;
            end else begin
                load_ir = 1'b1;
                pc_d    = pc_q + ADDR_W'(1);
                state_d = FULL;
            end
        end else if (transfer) begin
            state_d = EMPTY;
        end
    end

    always_comb begin
        rom_addr = pc_q;
        pc       = pc_q;
        ir       = ir_q;
        ir_pc    = ir_pc_q;
        ir_valid = (state_q == FULL);
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: scoreboard of issued (instruction, pc) pairs
// consumed on each decode transfer, plus per-scenario direct checks.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_en;
    logic [3:0]  rom_addr;
    logic [15:0] rom_data;
    logic [15:0] ir;
    logic [3:0]  ir_pc;
    logic        ir_valid;
    logic        ir_ready;
    logic        redirect_valid;
    logic [3:0]  redirect_target;
    logic [3:0]  pc;

    logic [15:0] rom [0:15];

    typedef struct {
        logic [15:0] ins;
        logic [3:0]  addr;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    fetch_unit #(.ADDR_W(4), .INST_W(16), .RESET_PC(4'd0)) dut (
        .clk             (clk),
        .rst             (rst),
        .fetch_en        (fetch_en),
        .rom_addr        (rom_addr),
        .rom_data        (rom_data),
        .ir              (ir),
        .ir_pc           (ir_pc),
        .ir_valid        (ir_valid),
        .ir_ready        (ir_ready),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .pc              (pc)
    );

    always #5 clk = ~clk;

    always_comb rom_data = rom[rom_addr];

    // Transfers happen at the next rising edge; inputs are stable at the falling edge.
    always @(negedge clk) begin
        if (!rst && ir_valid === 1'b1 && ir_ready === 1'b1) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected ir=%h ir_pc=%0d, no transfer expected", ir, ir_pc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if (ir !== e.ins || ir_pc !== e.addr) begin
                    errors++;
                    $display("FAIL sb_transfer ir=%h ir_pc=%0d, expected ir=%h ir_pc=%0d",
                             ir, ir_pc, e.ins, e.addr);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] ins, input logic [3:0] addr);
        exp_t e;
        e.ins  = ins;
        e.addr = addr;
        sb_q.push_back(e);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        fetch_en = 1'b0;
        ir_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_target = 4'd0;
        #3;
        checks++;
        if (ir_valid !== 1'b0 || pc !== 4'd0 || ir !== 16'h0000 || ir_pc !== 4'd0) begin
            errors++;
            $display("FAIL reset_state v=%b pc=%0d ir=%h ir_pc=%0d, expected v=0 pc=0 ir=0000 ir_pc=0",
                     ir_valid, pc, ir, ir_pc);
        end
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (ir_valid !== 1'b0 || pc !== 4'd0) begin
            errors++;
            $display("FAIL idle_hold v=%b pc=%0d, expected v=0 pc=0", ir_valid, pc);
        end
    endtask

    task automatic test_stream();
        fetch_en = 1'b1;
        ir_ready = 1'b1;
        push(16'h1201, 4'd0);
        push(16'hB401, 4'd1);
        push(rom[2], 4'd2);
        tick();
        checks++;
        if (ir !== 16'h1201 || ir_pc !== 4'd0 || ir_valid !== 1'b1 || pc !== 4'd1) begin
            errors++;
            $display("FAIL stream_c1 ir=%h ir_pc=%0d v=%b pc=%0d, expected ir=1201 ir_pc=0 v=1 pc=1",
                     ir, ir_pc, ir_valid, pc);
        end
        tick();
        checks++;
        if (ir !== 16'hB401 || ir_pc !== 4'd1 || ir_valid !== 1'b1 || pc !== 4'd2) begin
            errors++;
            $display("FAIL stream_c2 ir=%h ir_pc=%0d v=%b pc=%0d, expected ir=B401 ir_pc=1 v=1 pc=2",
                     ir, ir_pc, ir_valid, pc);
        end
        tick();
    endtask

    task automatic test_stall();
        ir_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (ir !== rom[2] || ir_pc !== 4'd2 || ir_valid !== 1'b1 || pc !== 4'd3) begin
                errors++;
                $display("FAIL stall_hold%0d ir=%h ir_pc=%0d v=%b pc=%0d, expected ir=%h ir_pc=2 v=1 pc=3",
                         i, ir, ir_pc, ir_valid, pc, rom[2]);
            end
        end
        ir_ready = 1'b1;
        tick();
        checks++;
        if (ir_pc !== 4'd3 || ir !== rom[3] || pc !== 4'd4) begin
            errors++;
            $display("FAIL stall_release ir=%h ir_pc=%0d pc=%0d, expected ir=%h ir_pc=3 pc=4",
                     ir, ir_pc, pc, rom[3]);
        end
    endtask

    task automatic test_redirect();
        ir_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_target = 4'd10;
        tick();
        redirect_valid = 1'b0;
        checks++;
        if (ir_valid !== 1'b0 || pc !== 4'd10) begin
            errors++;
            $display("FAIL redirect_flush v=%b pc=%0d, expected v=0 pc=10", ir_valid, pc);
        end
        ir_ready = 1'b1;
        push(16'hF200, 4'd10);
        tick();
        checks++;
        if (ir !== 16'hF200 || ir_pc !== 4'd10 || ir_valid !== 1'b1) begin
            errors++;
            $display("FAIL redirect_fetch ir=%h ir_pc=%0d v=%b, expected ir=F200 ir_pc=10 v=1",
                     ir, ir_pc, ir_valid);
        end
    endtask

    task automatic test_jmp();
`ifdef FETCH_JMP_FOLD_EN
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (ir_valid !== 1'b0 || pc !== 4'd10) begin
                errors++;
                $display("FAIL jmp_fold%0d v=%b pc=%0d, expected v=0 pc=10", i, ir_valid, pc);
            end
            push(16'hF200, 4'd10);
            tick();
            checks++;
            if (ir !== 16'hF200 || ir_pc !== 4'd10 || ir_valid !== 1'b1 || pc !== 4'd11) begin
                errors++;
                $display("FAIL jmp_loop%0d ir=%h ir_pc=%0d v=%b pc=%0d, expected ir=F200 ir_pc=10 v=1 pc=11",
                         i, ir, ir_pc, ir_valid, pc);
            end
        end
        fetch_en = 1'b0;
        tick();
        checks++;
        if (ir_valid !== 1'b0 || pc !== 4'd11) begin
            errors++;
            $display("FAIL jmp_drain v=%b pc=%0d, expected v=0 pc=11", ir_valid, pc);
        end
`else
        push(16'h8A00, 4'd11);
        tick();
        checks++;
        if (ir !== 16'h8A00 || ir_pc !== 4'd11 || ir_valid !== 1'b1 || pc !== 4'd12) begin
            errors++;
            $display("FAIL jmp_issue ir=%h ir_pc=%0d v=%b pc=%0d, expected ir=8A00 ir_pc=11 v=1 pc=12",
                     ir, ir_pc, ir_valid, pc);
        end
        fetch_en = 1'b0;
        tick();
        checks++;
        if (ir_valid !== 1'b0 || pc !== 4'd12) begin
            errors++;
            $display("FAIL jmp_drain v=%b pc=%0d, expected v=0 pc=12", ir_valid, pc);
        end
`endif
    endtask

    task automatic test_wrap();
        logic [3:0] exp_pc [0:3];
        exp_pc[0] = 4'd14;
        exp_pc[1] = 4'd15;
        exp_pc[2] = 4'd0;
        exp_pc[3] = 4'd1;
        redirect_valid = 1'b1;
        redirect_target = 4'd14;
        tick();
        redirect_valid = 1'b0;
        checks++;
        if (pc !== 4'd14 || ir_valid !== 1'b0) begin
            errors++;
            $display("FAIL wrap_redirect_idle pc=%0d v=%b, expected pc=14 v=0", pc, ir_valid);
        end
        fetch_en = 1'b1;
        for (int i = 0; i < 4; i++) push(rom[exp_pc[i]], exp_pc[i]);
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (ir_pc !== exp_pc[i] || ir !== rom[exp_pc[i]] || ir_valid !== 1'b1) begin
                errors++;
                $display("FAIL wrap_seq%0d ir_pc=%0d ir=%h v=%b, expected ir_pc=%0d ir=%h v=1",
                         i, ir_pc, ir, ir_valid, exp_pc[i], rom[exp_pc[i]]);
            end
        end
        fetch_en = 1'b0;
        tick();
    endtask

    task automatic test_async_reset();
        fetch_en = 1'b1;
        ir_ready = 1'b0;
        tick();
        checks++;
        if (ir_valid !== 1'b1 || ir_pc !== 4'd2 || pc !== 4'd3) begin
            errors++;
            $display("FAIL areset_setup v=%b ir_pc=%0d pc=%0d, expected v=1 ir_pc=2 pc=3", ir_valid, ir_pc, pc);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (ir_valid !== 1'b0 || pc !== 4'd0 || ir !== 16'h0000 || ir_pc !== 4'd0) begin
            errors++;
            $display("FAIL areset_async v=%b pc=%0d ir=%h ir_pc=%0d, expected v=0 pc=0 ir=0000 ir_pc=0",
                     ir_valid, pc, ir, ir_pc);
        end
        fetch_en = 1'b0;
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rom[i] = {4'h2, i[3:0], 8'h55};
        rom[0]  = 16'h1201;
        rom[1]  = 16'hB401;
        rom[10] = 16'hF200;
        rom[11] = 16'h8A00;
        rom[14] = 16'h5E0E;
        rom[15] = 16'h6F0F;

        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_jmp();
        test_wrap();
        test_async_reset();

        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain pending=%0d, expected 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
